// File: rtl/c_fetch_ctrl.sv
// c_fetch_ctrl: RV32IC fetch sequencer. Owns the halfword-aligned PC, drives a word-aligned
// instruction-memory address and realigns compressed / word-straddling instructions so that
// one aligned instruction leaves per output beat.
// Optional feature macro: C_EXT_EN (compressed support). Undefined builds an RV32I-only
// sequencer with no split state and no halfword buffer.
module c_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        stall_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic        inst_valid_o,
  output logic        inst_is_c_o,
  output logic        stall_pc_o
);

  // pc_q holds pc[31:1]; bit 0 of the PC is always zero
  logic [30:0] pc_q, pc_d;
  logic [31:0] pc_full;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;

  assign pc_full = {pc_q, 1'b0};

`ifdef C_EXT_EN
  typedef enum logic [0:0] {StRun, StSplit} state_e;

  localparam logic [30:0] ResetPcHw = RESET_PC[31:1];

  state_e      state_q, state_d;
  logic [15:0] hbuf_q, hbuf_d;
  logic        is_c_q, is_c_d;
  logic        unused_br_bit;

  assign unused_br_bit = br_target_i[0];
`else
  // RV32I only: pc[1] is forced low, including on reset
  localparam logic [30:0] ResetPcHw = {RESET_PC[31:2], 1'b0};

  logic [1:0] unused_br_bits;

  assign unused_br_bits = br_target_i[1:0];
`endif

  // State register: pc, FSM, halfword buffer and registered instruction outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q      <= ResetPcHw;
      inst_q    <= '0;
      inst_pc_q <= '0;
      valid_q   <= 1'b0;
`ifdef C_EXT_EN
      state_q   <= StRun;
      hbuf_q    <= '0;
      is_c_q    <= 1'b0;
`endif
    end else begin
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      valid_q   <= valid_d;
`ifdef C_EXT_EN
      state_q   <= state_d;
      hbuf_q    <= hbuf_d;
      is_c_q    <= is_c_d;
`endif
    end
  end

  // Next-state: branch beats stall beats normal sequencing
  always_comb begin
    pc_d      = pc_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    valid_d   = valid_q;
`ifdef C_EXT_EN
    state_d   = state_q;
    hbuf_d    = hbuf_q;
    is_c_d    = is_c_q;
    if (br_taken_i) begin
      // The word fetched this cycle is dropped along with any buffered half
      pc_d    = br_target_i[31:1];
      state_d = StRun;
      hbuf_d  = '0;
      valid_d = 1'b0;
    end else if (!stall_i) begin
      unique case (state_q)
        StRun: begin
          if (!pc_q[0]) begin
            inst_pc_d = pc_full;
            valid_d   = 1'b1;
            if (imem_rdata_i[1:0] != 2'b11) begin
              inst_d = {16'h0000, imem_rdata_i[15:0]};
              is_c_d = 1'b1;
              pc_d   = pc_q + 31'd1;
            end else begin
              inst_d = imem_rdata_i;
              is_c_d = 1'b0;
              pc_d   = pc_q + 31'd2;
            end
          end else if (imem_rdata_i[17:16] != 2'b11) begin
            inst_d    = {16'h0000, imem_rdata_i[31:16]};
            inst_pc_d = pc_full;
            valid_d   = 1'b1;
            is_c_d    = 1'b1;
            pc_d      = pc_q + 31'd1;
          end else begin
            // Lower half of a straddling instruction; upper half comes from the next word
            hbuf_d  = imem_rdata_i[31:16];
            valid_d = 1'b0;
            state_d = StSplit;
          end
        end
        StSplit: begin
          inst_d    = {imem_rdata_i[15:0], hbuf_q};
          inst_pc_d = pc_full;
          valid_d   = 1'b1;
          is_c_d    = 1'b0;
          pc_d      = pc_q + 31'd2;
          state_d   = StRun;
        end
      endcase
    end
`else
    if (br_taken_i) begin
      pc_d    = {br_target_i[31:2], 1'b0};
      valid_d = 1'b0;
    end else if (!stall_i) begin
      inst_d    = imem_rdata_i;
      inst_pc_d = pc_full;
      valid_d   = 1'b1;
      pc_d      = pc_q + 31'd2;
    end
`endif
  end

  // Outputs: fetch address and split indicator are combinational from state
  always_comb begin
    imem_addr_o = {pc_q[30:1], 2'b00};
    stall_pc_o  = 1'b0;
`ifdef C_EXT_EN
    if (state_q == StSplit) begin
      imem_addr_o = {pc_q[30:1] + 30'd1, 2'b00};
      stall_pc_o  = 1'b1;
    end
`endif
  end

  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = valid_q;
`ifdef C_EXT_EN
  assign inst_is_c_o  = is_c_q;
`else
  assign inst_is_c_o  = 1'b0;
`endif

endmodule

// File: tb/tb_c_fetch_ctrl.sv
// Directed bench for c_fetch_ctrl; exercises the C_EXT_EN or RV32I build to match the RTL.
module tb_c_fetch_ctrl;

  logic        clk;
  logic        reset;
  logic        br_taken;
  logic [31:0] br_target;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_is_c;
  logic        stall_pc;

  logic [31:0] mem [256];
  int n_vec = 0;
  int n_err = 0;

  c_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .br_taken_i  (br_taken),
    .br_target_i (br_target),
    .stall_i     (stall),
    .imem_addr_o (imem_addr),
    .imem_rdata_i(imem_rdata),
    .inst_o      (inst),
    .inst_pc_o   (inst_pc),
    .inst_valid_o(inst_valid),
    .inst_is_c_o (inst_is_c),
    .stall_pc_o  (stall_pc)
  );

  // 1 KiB memory image aliased over the whole address space; 0xFFFFFFFC maps to entry 255
  always_comb imem_rdata = mem[imem_addr[9:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary, required summary");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_inst(input string tag, input logic [31:0] i, input logic [31:0] pc,
                             input logic c);
    check_eq({tag, ".valid"}, {31'd0, inst_valid}, 32'd1);
    check_eq({tag, ".inst"}, inst, i);
    check_eq({tag, ".pc"}, inst_pc, pc);
    check_eq({tag, ".is_c"}, {31'd0, inst_is_c}, {31'd0, c});
    check_eq({tag, ".stall_pc"}, {31'd0, stall_pc}, 32'd0);
  endtask

  task automatic expect_bubble(input string tag, input logic sp);
    check_eq({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
    check_eq({tag, ".stall_pc"}, {31'd0, stall_pc}, {31'd0, sp});
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, ".inst"}, inst, 32'd0);
    check_eq({tag, ".pc"}, inst_pc, 32'd0);
    check_eq({tag, ".valid"}, {31'd0, inst_valid}, 32'd0);
    check_eq({tag, ".is_c"}, {31'd0, inst_is_c}, 32'd0);
    check_eq({tag, ".stall_pc"}, {31'd0, stall_pc}, 32'd0);
    check_eq({tag, ".addr"}, imem_addr, 32'd0);
  endtask

  // Asynchronous reset pulse placed mid-cycle, checked while held
  task automatic do_reset(input string tag);
    reset = 1'b0;
    #1;
    check_reset_state(tag);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    reset     = 1'b1;
    br_taken  = 1'b0;
    br_target = 32'd0;
    stall     = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0000_0013;
    mem[0]  = 32'h006F_C104;
    mem[1]  = 32'h4104_0040;
    mem[64] = 32'h00A0_0093;
    mem[65] = 32'h00B0_0113;
    mem[66] = 32'h4505_4104;
    #2;
    do_reset("por");

`ifdef C_EXT_EN
    // Compressed followed by a straddling 32-bit instruction
    tick(); expect_inst("t1.c0", 32'h0000_C104, 32'h0, 1'b1);
    check_eq("t1.addr0", imem_addr, 32'h0);
    tick(); expect_bubble("t1.split", 1'b1);
    check_eq("t1.addr_split", imem_addr, 32'h4);
    tick(); expect_inst("t1.w", 32'h0040_006F, 32'h2, 1'b0);
    tick(); expect_inst("t1.c1", 32'h0000_4104, 32'h6, 1'b1);

    // Second straddling pattern
    mem[0] = 32'h0863_C104;
    mem[1] = 32'h4104_0094;
    @(posedge clk); #1;
    do_reset("t2.rst");
    tick(); expect_inst("t2.c0", 32'h0000_C104, 32'h0, 1'b1);
    tick(); expect_bubble("t2.split", 1'b1);
    tick(); expect_inst("t2.w", 32'h0094_0863, 32'h2, 1'b0);

    // Branch taken during the split cycle, stall also high: branch wins
    do_reset("t3.rst");
    tick(); tick();
    expect_bubble("t3.pre", 1'b1);
    br_taken = 1'b1; br_target = 32'h0000_0101; stall = 1'b1;
    tick();
    br_taken = 1'b0; stall = 1'b0;
    expect_bubble("t3.br", 1'b0);
    check_eq("t3.addr", imem_addr, 32'h100);
    tick(); expect_inst("t3.tgt", 32'h00A0_0093, 32'h100, 1'b0);

    // Stall three cycles: everything frozen, then resume in order
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_inst("t4.hold", 32'h00A0_0093, 32'h100, 1'b0);
      check_eq("t4.addr", imem_addr, 32'h104);
    end
    stall = 1'b0;
    tick(); expect_inst("t4.r0", 32'h00B0_0113, 32'h104, 1'b0);
    tick(); expect_inst("t4.r1", 32'h0000_4104, 32'h108, 1'b1);
    tick(); expect_inst("t4.r2", 32'h0000_4505, 32'h10A, 1'b1);

    // Straddle across the top of the address space
    mem[255] = 32'h0513_0001;
    br_taken = 1'b1; br_target = 32'hFFFF_FFFE;
    tick();
    br_taken = 1'b0;
    expect_bubble("t5.br", 1'b0);
    check_eq("t5.addr0", imem_addr, 32'hFFFF_FFFC);
    tick(); expect_bubble("t5.split", 1'b1);
    check_eq("t5.addr1", imem_addr, 32'h0);
    tick(); expect_inst("t5.w", 32'hC104_0513, 32'hFFFF_FFFE, 1'b0);

    // Reset asserted while in SPLIT
    mem[0] = 32'h006F_C104;
    mem[1] = 32'h4104_0040;
    do_reset("t6.rst0");
    tick(); tick();
    expect_bubble("t6.split", 1'b1);
    do_reset("t6.rst1");
    tick(); expect_inst("t6.first", 32'h0000_C104, 32'h0, 1'b1);
`else
    // RV32I: every word is a 32-bit instruction
    tick(); expect_inst("i1.w0", 32'h006F_C104, 32'h0, 1'b0);
    check_eq("i1.addr", imem_addr, 32'h4);
    tick(); expect_inst("i1.w1", 32'h4104_0040, 32'h4, 1'b0);

    // Branch with stall high; target bits [1:0] ignored
    br_taken = 1'b1; br_target = 32'h0000_0103; stall = 1'b1;
    tick();
    br_taken = 1'b0; stall = 1'b0;
    expect_bubble("i2.br", 1'b0);
    check_eq("i2.addr", imem_addr, 32'h100);
    tick(); expect_inst("i2.tgt", 32'h00A0_0093, 32'h100, 1'b0);

    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_inst("i3.hold", 32'h00A0_0093, 32'h100, 1'b0);
      check_eq("i3.addr", imem_addr, 32'h104);
    end
    stall = 1'b0;
    tick(); expect_inst("i3.r0", 32'h00B0_0113, 32'h104, 1'b0);
    tick(); expect_inst("i3.r1", 32'h4505_4104, 32'h108, 1'b0);

    // PC wrap
    mem[255] = 32'h00C0_0193;
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    expect_bubble("i4.br", 1'b0);
    check_eq("i4.addr", imem_addr, 32'hFFFF_FFFC);
    tick(); expect_inst("i4.top", 32'h00C0_0193, 32'hFFFF_FFFC, 1'b0);
    check_eq("i4.addr_wrap", imem_addr, 32'h0);
    tick(); expect_inst("i4.zero", 32'h006F_C104, 32'h0, 1'b0);

    // Reset mid-stream
    do_reset("i5.rst");
    tick(); expect_inst("i5.first", 32'h006F_C104, 32'h0, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
